// File: rtl/vital_alert_ctrl.sv
// Alert controller behind the smart-ring vitals core: confirms emergencies, latches the alarm and buzzer,
// slew-limits oxygen delivery and counts confirmed events until the user acknowledges.
module vital_alert_ctrl #(
  parameter int unsigned CONFIRM_N = 3,
  parameter int unsigned STEP      = 8,
  parameter int unsigned O2_FLOOR  = 64,
  parameter int unsigned BUZZ_HALF = 4,
  parameter int unsigned COOLDOWN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] o2_req,
  input  logic       emerg,
  input  logic       ack,
  output logic [7:0] o2_level,
  output logic       o2_valid,
  output logic       alarm,
  output logic       buzzer,
  output logic [7:0] event_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CONFIRM  = 2'd1,
    S_ALARM    = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  localparam int unsigned BZ_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [3:0]      CONF_N   = 4'(CONFIRM_N);
  localparam logic [7:0]      STEP_8   = 8'(STEP);
  localparam logic [8:0]      STEP_9   = {1'b0, STEP_8};
  localparam logic [7:0]      FLOOR_8  = 8'(O2_FLOOR);
  localparam logic [BZ_W-1:0] BZ_LAST  = BZ_W'(BUZZ_HALF - 1);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN - 1);

  state_e          state_q, state_d;
  logic [3:0]      conf_q, conf_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [BZ_W-1:0] bz_q, bz_d;
  logic [7:0]      level_q, level_d;
  logic            valid_q, valid_d;
  logic            alarm_q, alarm_d;
  logic            buzz_q, buzz_d;
  logic [7:0]      evt_q, evt_d;

  logic [7:0] target;
  logic [8:0] diff;

  // Ramp: the ALARM floor applies based on the state held before this edge.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    target  = o2_req;
    diff    = '0;
    level_d = level_q;
    valid_d = sample_valid;
    if (state_q == S_ALARM && o2_req < FLOOR_8) target = FLOOR_8;
    if (sample_valid) begin
      if (target > level_q) begin
        diff    = {1'b0, target} - {1'b0, level_q};
        level_d = (diff > STEP_9) ? level_q + STEP_8 : target;
      end else if (target < level_q) begin
        diff    = {1'b0, level_q} - {1'b0, target};
        level_d = (diff > STEP_9) ? level_q - STEP_8 : target;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    cd_d    = cd_q;
    bz_d    = bz_q;
    alarm_d = alarm_q;
    buzz_d  = buzz_q;
    evt_d   = evt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sample_valid && emerg) begin
          if (CONFIRM_N == 1) begin
            state_d = S_ALARM;
            conf_d  = '0;
          end else begin
            state_d = S_CONFIRM;
            conf_d  = 4'd1;
          end
        end
      end
      S_CONFIRM: begin
        if (sample_valid) begin
          if (!emerg) begin
            state_d = S_IDLE;
            conf_d  = '0;
          end else if (conf_q + 4'd1 == CONF_N) begin
            state_d = S_ALARM;
            conf_d  = '0;
          end else begin
            conf_d = conf_q + 4'd1;
          end
        end
      end
      S_ALARM: begin
        // Acknowledge takes priority over buzzer timing and any sample this cycle.
        if (ack) begin
          state_d = S_COOLDOWN;
          alarm_d = 1'b0;
          buzz_d  = 1'b0;
          bz_d    = '0;
          cd_d    = CD_LOAD;
        end else if (bz_q == BZ_LAST) begin
          bz_d   = '0;
          buzz_d = ~buzz_q;
        end else begin
          bz_d = bz_q + 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (cd_q == '0) state_d = S_IDLE;
        else            cd_d    = cd_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_ALARM && state_d == S_ALARM) begin
      alarm_d = 1'b1;
      buzz_d  = 1'b1;
      bz_d    = '0;
      if (evt_q != 8'hFF) evt_d = evt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      conf_q  <= '0;
      cd_q    <= '0;
      bz_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      buzz_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      cd_q    <= cd_d;
      bz_q    <= bz_d;
      level_q <= level_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
      buzz_q  <= buzz_d;
      evt_q   <= evt_d;
    end
  end

  assign o2_level  = level_q;
  assign o2_valid  = valid_q;
  assign alarm     = alarm_q;
  assign buzzer    = buzz_q;
  assign event_cnt = evt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_vital_alert_ctrl.sv
// Directed bench for vital_alert_ctrl: ramp scoreboard, confirm/alarm/ack/cooldown sequencing,
// async reset and event counter saturation on a second CONFIRM_N=1 instance.
module tb_vital_alert_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sample_valid, emerg, ack;
  logic [7:0] o2_req;
  logic [7:0] o2_level, event_cnt;
  logic       o2_valid, alarm, buzzer;
  logic [1:0] state;

  logic       sv2, em2, ack2;
  logic [7:0] lvl2, ev2;
  logic       vld2, alm2, bz2;
  logic [1:0] st2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_level;
  bit         m_alarm;

  vital_alert_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .o2_req(o2_req),
    .emerg(emerg), .ack(ack), .o2_level(o2_level), .o2_valid(o2_valid),
    .alarm(alarm), .buzzer(buzzer), .event_cnt(event_cnt), .state(state)
  );

  vital_alert_ctrl #(.CONFIRM_N(1), .BUZZ_HALF(1), .COOLDOWN(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv2), .o2_req(o2_req),
    .emerg(em2), .ack(ack2), .o2_level(lvl2), .o2_valid(vld2),
    .alarm(alm2), .buzzer(bz2), .event_cnt(ev2), .state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ramp_model(input logic [7:0] lvl, input logic [7:0] req,
                                            input bit in_alarm);
    int tgt, l;
    tgt = (in_alarm && req < 64) ? 64 : int'(req);
    l   = int'(lvl);
    if (tgt > l)      l = l + ((tgt - l > 8) ? 8 : tgt - l);
    else if (tgt < l) l = l - ((l - tgt > 8) ? 8 : l - tgt);
    return 8'(l);
  endfunction

  // Drives one accepted sample, pushes the predicted level and pops it when o2_valid appears.
  task automatic sample(input logic [7:0] req, input logic em, input logic a);
    logic [7:0] want;
    o2_req       = req;
    emerg        = em;
    ack          = a;
    sample_valid = 1'b1;
    exp_level    = ramp_model(exp_level, req, m_alarm);
    exp_q.push_back(exp_level);
    tick();
    sample_valid = 1'b0;
    emerg        = 1'b0;
    ack          = 1'b0;
    check("o2_valid", o2_valid, 1);
    want = exp_q.pop_front();
    if (o2_valid === 1'b1) check("o2_level", o2_level, want);
  endtask

  initial begin
    int ems[6]    = '{1, 1, 0, 1, 1, 1};
    int states[6] = '{1, 1, 0, 1, 1, 2};

    rst_n = 1'b0; sample_valid = 1'b0; emerg = 1'b0; ack = 1'b0; o2_req = '0;
    sv2 = 1'b0; em2 = 1'b0; ack2 = 1'b0;
    exp_level = '0; m_alarm = 1'b0;

    #12;
    check("rst_level", o2_level, 0);
    check("rst_valid", o2_valid, 0);
    check("rst_alarm", alarm, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_event", event_cnt, 0);
    check("rst_state", state, 0);
    check("rst_event2", ev2, 0);
    rst_n = 1'b1;
    tick();

    // Ramp up then down.
    for (int i = 0; i < 13; i++) sample(8'd100, 1'b0, 1'b0);
    check("ramp_top", o2_level, 100);
    tick();
    check("valid_pulse", o2_valid, 0);
    check("hold_level", o2_level, 100);
    for (int i = 0; i < 13; i++) sample(8'd0, 1'b0, 1'b0);
    check("ramp_bottom", o2_level, 0);
    check("idle_state", state, 0);

    // Confirm sequence with an interrupting emerg=0.
    for (int i = 0; i < 6; i++) begin
      sample(8'd40, ems[i][0], 1'b0);
      check("confirm_state", state, states[i]);
      check("confirm_alarm", alarm, (i == 5) ? 1 : 0);
    end
    m_alarm = 1'b1;
    check("event_first", event_cnt, 1);
    for (int t = 0; t < 12; t++) begin
      check("buzz_wave", buzzer, ((t / 4) % 2 == 0) ? 1 : 0);
      tick();
    end

    // Floor while alarmed; alarm stays latched with emerg low.
    for (int i = 0; i < 4; i++) sample(8'd10, 1'b0, 1'b0);
    check("floor_level", o2_level, 64);
    check("latched_alarm", alarm, 1);
    check("latched_state", state, 2);

    // Ack together with a sample: ramp still uses the floor target.
    sample(8'd10, 1'b0, 1'b1);
    m_alarm = 1'b0;
    check("ack_alarm", alarm, 0);
    check("ack_buzzer", buzzer, 0);
    check("ack_state", state, 3);
    for (int i = 0; i < 15; i++) begin
      sample(8'd64, 1'b1, 1'b0);
      check("cool_state", state, 3);
      check("cool_alarm", alarm, 0);
    end
    tick();
    check("cool_done", state, 0);
    check("cool_event", event_cnt, 1);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_idle_state", state, 0);
    check("ack_idle_alarm", alarm, 0);

    // Re-alarm, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 3; i++) sample(8'd64, 1'b1, 1'b0);
    m_alarm = 1'b1;
    check("realarm_state", state, 2);
    check("realarm_event", event_cnt, 2);
    tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_alarm", alarm, 0);
    check("arst_buzzer", buzzer, 0);
    check("arst_level", o2_level, 0);
    check("arst_event", event_cnt, 0);
    check("arst_state", state, 0);
    sample_valid = 1'b1; emerg = 1'b1; o2_req = 8'd200;
    tick();
    sample_valid = 1'b0; emerg = 1'b0;
    check("rst_drop_valid", o2_valid, 0);
    check("rst_drop_level", o2_level, 0);
    #2 rst_n = 1'b1;
    exp_level = '0;
    m_alarm   = 1'b0;
    sample(8'd20, 1'b0, 1'b0);
    check("post_rst_state", state, 0);

    // Saturation of event_cnt on the CONFIRM_N=1 instance.
    for (int k = 1; k <= 257; k++) begin
      sv2 = 1'b1; em2 = 1'b1;
      tick();
      sv2 = 1'b0; em2 = 1'b0;
      check("sat_state_alarm", st2, 2);
      check("sat_event", ev2, (k > 255) ? 255 : k);
      ack2 = 1'b1;
      tick();
      ack2 = 1'b0;
      check("sat_state_cool", st2, 3);
      tick();
      tick();
      check("sat_state_idle", st2, 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
